mdu_ctrl: RTL and testbench

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_ctrl_if.sv | 22 ++
 rtl/mdu_ctrl.sv | 133 +++++++++++++
 tb/tb_mdu_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/mdu_ctrl_if.sv
// Request/response bundle between the decode stage and the multiply/divide unit.
// Decode drives the request fields; the unit reports busy, a done pulse and the result.
interface mdu_ctrl_if;
  logic        ID_start;
  logic        ID_flush;
  logic [2:0]  ID_fn_3;
  logic [31:0] ID_rs1_val;
  logic [31:0] ID_rs2_val;
  logic        MDU_busy;
  logic        MDU_done;
  logic [31:0] MDU_result;

  modport master (
    output ID_start, ID_flush, ID_fn_3, ID_rs1_val, ID_rs2_val,
    input  MDU_busy, MDU_done, MDU_result
  );

  modport slave (
    input  ID_start, ID_flush, ID_fn_3, ID_rs1_val, ID_rs2_val,
    output MDU_busy, MDU_done, MDU_result
  );
endinterface

// File: rtl/mdu_ctrl.sv
// Iterative RV32M multiply/divide unit; 33 cycles from accept to done, done state included in busy.
// No queuing: starts are taken only in IDLE (flush wins), and flush or reset abandons the operation.
module mdu_ctrl (
  input  logic       clk,
  input  logic       rst,
  mdu_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, state_nxt;
  logic [5:0]  cnt;
  logic [2:0]  fn;
  logic [31:0] rs1_q;
  logic [31:0] b_mag;
  logic [31:0] hi, lo;
  logic        a_neg, b_neg;
  logic [31:0] result;

  logic        accept, last_iter;
  logic        a_signed_in, b_signed_in, a_neg_in, b_neg_in;
  logic [31:0] a_mag_in, b_mag_in;
  logic [32:0] sum, shifted, diff;
  logic [31:0] hi_n, lo_n;
  logic [63:0] prod, prod_s;
  logic [31:0] quot, remv, fin;

  assign accept    = (state == IDLE) && bus.ID_start && !bus.ID_flush;
  assign last_iter = (state == BUSY) && (cnt == 6'd1) && !bus.ID_flush;

  // Signedness per funct3: MUL/MULH/DIV/REM signed, MULHSU signed rs1 only.
  always_comb begin
    if (bus.ID_fn_3[2]) begin
      a_signed_in = !bus.ID_fn_3[0];
      b_signed_in = !bus.ID_fn_3[0];
    end else begin
      a_signed_in = (bus.ID_fn_3[1:0] != 2'b11);
      b_signed_in = !bus.ID_fn_3[1];
    end
    a_neg_in = a_signed_in && bus.ID_rs1_val[31];
    b_neg_in = b_signed_in && bus.ID_rs2_val[31];
    a_mag_in = a_neg_in ? (32'd0 - bus.ID_rs1_val) : bus.ID_rs1_val;
    b_mag_in = b_neg_in ? (32'd0 - bus.ID_rs2_val) : bus.ID_rs2_val;
  end

  // One iteration: {hi,lo} is the product/partial-product pair for multiply,
  // remainder/quotient pair for restoring divide.
  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, b_mag} : 33'd0);
    shifted = {hi, lo[31]};
    diff    = shifted - {1'b0, b_mag};
    if (fn[2]) begin
      if (!diff[32]) begin
        hi_n = diff[31:0];
        lo_n = {lo[30:0], 1'b1};
      end else begin
        hi_n = shifted[31:0];
        lo_n = {lo[30:0], 1'b0};
      end
    end else begin
      hi_n = sum[32:1];
      lo_n = {sum[0], lo[31:1]};
    end
  end

  always_comb begin
    prod   = {hi_n, lo_n};
    prod_s = (a_neg ^ b_neg) ? (64'd0 - prod) : prod;
    quot   = (a_neg ^ b_neg) ? (32'd0 - lo_n) : lo_n;
    remv   = a_neg ? (32'd0 - hi_n) : hi_n;
    if (!fn[2]) begin
      fin = (fn[1:0] == 2'b00) ? prod_s[31:0] : prod_s[63:32];
    end else if (b_mag == 32'd0) begin
      fin = fn[1] ? rs1_q : 32'hFFFF_FFFF;
    end else begin
      fin = fn[1] ? remv : quot;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = BUSY;
      BUSY:    if (bus.ID_flush) state_nxt = IDLE;
               else if (cnt == 6'd1) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.MDU_busy   = (state != IDLE);
    bus.MDU_done   = (state == DONE);
    bus.MDU_result = result;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= 6'd0;
      fn    <= 3'd0;
      rs1_q <= 32'd0;
      b_mag <= 32'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
      a_neg <= 1'b0;
      b_neg <= 1'b0;
    end else if (accept) begin
      cnt   <= 6'd32;
      fn    <= bus.ID_fn_3;
      rs1_q <= bus.ID_rs1_val;
      b_mag <= b_mag_in;
      hi    <= 32'd0;
      lo    <= a_mag_in;
      a_neg <= a_neg_in;
      b_neg <= b_neg_in;
    end else if (state == BUSY && !bus.ID_flush) begin
      cnt <= cnt - 6'd1;
      hi  <= hi_n;
      lo  <= lo_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            result <= 32'd0;
    else if (last_iter) result <= fin;
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed table of RV32M vectors plus flush, reset and spurious-start sequences,
// checked through an expected-result queue against mdu_ctrl.
module tb_mdu_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_done = 0;
  int   total = 0;
  int   pass = 0;
  logic [31:0] exp_q[$];

  mdu_ctrl_if bus ();

  mdu_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (bus.MDU_done) n_done <= n_done + 1;

  typedef struct {
    logic [2:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    string       nm;
  } vec_t;

  vec_t vecs[16];

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
    total++;
    if (act === req) pass++;
    else $display("FAIL %s: got %h required %h", nm, act, req);
  endfunction

  // Expects to be called between edges with the unit in IDLE.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] e, input string nm, input int spurious);
    int  acc;
    bit  got;
    logic [31:0] want;
    bus.ID_start   = 1'b1;
    bus.ID_fn_3    = f;
    bus.ID_rs1_val = a;
    bus.ID_rs2_val = b;
    acc = cyc;
    exp_q.push_back(e);
    got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      bus.ID_start = (spurious != 0) && (cyc - acc == spurious);
      if (bus.ID_start) begin
        bus.ID_fn_3    = 3'b000;
        bus.ID_rs1_val = 32'h1234_5678;
        bus.ID_rs2_val = 32'd3;
      end
      if (bus.MDU_done) got = 1;
    end
    bus.ID_start = 1'b0;
    chk({nm, " done_seen"}, 32'(got), 32'd1);
    if (got) begin
      chk({nm, " latency"}, 32'(cyc - acc), 32'd33);
      chk({nm, " busy_in_done"}, 32'(bus.MDU_busy), 32'd1);
      want = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      chk({nm, " result"}, bus.MDU_result, want);
    end else begin
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
    @(negedge clk);
    chk({nm, " idle_after"}, {30'd0, bus.MDU_busy, bus.MDU_done}, 32'd0);
  endtask

  initial begin
    int acc;
    int nd;
    logic [31:0] prev;

    vecs[0]  = '{3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, "MUL 7*-3"};
    vecs[1]  = '{3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, "MULH min*min"};
    vecs[2]  = '{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, "MULHU max*max"};
    vecs[3]  = '{3'b010, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, "MULHSU -1*2"};
    vecs[4]  = '{3'b101, 32'd100,        32'd7,         32'd14,        "DIVU 100/7"};
    vecs[5]  = '{3'b111, 32'd100,        32'd7,         32'd2,         "REMU 100/7"};
    vecs[6]  = '{3'b100, 32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFF2, "DIV -100/7"};
    vecs[7]  = '{3'b110, 32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFFE, "REM -100/7"};
    vecs[8]  = '{3'b100, 32'd5,          32'd0,         32'hFFFF_FFFF, "DIV 5/0"};
    vecs[9]  = '{3'b110, 32'd5,          32'd0,         32'd5,         "REM 5/0"};
    vecs[10] = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, "DIV ovf"};
    vecs[11] = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         "REM ovf"};
    vecs[12] = '{3'b110, 32'd100,        32'hFFFF_FFF9, 32'd2,         "REM 100/-7"};
    vecs[13] = '{3'b010, 32'd2,          32'hFFFF_FFFF, 32'd1,         "MULHSU 2*u"};
    vecs[14] = '{3'b000, 32'h1234_5678,  32'h10,        32'h2345_6780, "MUL low"};
    vecs[15] = '{3'b110, 32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB, "REM -5/0"};

    bus.ID_start   = 1'b0;
    bus.ID_flush   = 1'b0;
    bus.ID_fn_3    = 3'd0;
    bus.ID_rs1_val = 32'd0;
    bus.ID_rs2_val = 32'd0;

    #1;
    chk("reset outputs", {bus.MDU_result[29:0], bus.MDU_busy, bus.MDU_done}, 32'd0);
    chk("reset result", bus.MDU_result, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Consecutive calls start in the cycle right after DONE.
    for (int i = 0; i < 16; i++)
      run_op(vecs[i].fn, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].nm, (i == 4) ? 5 : 0);

    // Flush and start together in IDLE: flush wins.
    bus.ID_start = 1'b1;
    bus.ID_flush = 1'b1;
    bus.ID_fn_3  = 3'b101;
    @(negedge clk);
    bus.ID_start = 1'b0;
    bus.ID_flush = 1'b0;
    chk("flush beats start", 32'(bus.MDU_busy), 32'd0);

    // Flush in BUSY at cycle 10 after accept.
    prev = bus.MDU_result;
    nd = n_done;
    bus.ID_start   = 1'b1;
    bus.ID_fn_3    = 3'b101;
    bus.ID_rs1_val = 32'd1000;
    bus.ID_rs2_val = 32'd3;
    acc = cyc;
    @(negedge clk);
    bus.ID_start = 1'b0;
    for (int i = 0; i < 20 && (cyc - acc) < 10; i++) @(negedge clk);
    chk("busy before flush", 32'(bus.MDU_busy), 32'd1);
    bus.ID_flush = 1'b1;
    @(negedge clk);
    bus.ID_flush = 1'b0;
    chk("flush busy", 32'(bus.MDU_busy), 32'd0);
    chk("flush result", bus.MDU_result, prev);
    repeat (40) @(negedge clk);
    chk("flush no done", 32'(n_done - nd), 32'd0);
    chk("flush result held", bus.MDU_result, prev);

    // Asynchronous reset mid-BUSY.
    nd = n_done;
    bus.ID_start   = 1'b1;
    bus.ID_fn_3    = 3'b000;
    bus.ID_rs1_val = 32'd9;
    bus.ID_rs2_val = 32'd9;
    @(negedge clk);
    bus.ID_start = 1'b0;
    repeat (6) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async rst busy/done", {30'd0, bus.MDU_busy, bus.MDU_done}, 32'd0);
    chk("async rst result", bus.MDU_result, 32'd0);
    #7;
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("rst no done", 32'(n_done - nd), 32'd0);
    chk("rst idle", 32'(bus.MDU_busy), 32'd0);

    // Start taken on the first edge after reset release.
    rst = 1'b1;
    #1;
    rst = 1'b0;
    run_op(3'b000, 32'd6, 32'd7, 32'd42, "MUL after rst", 0);
    run_op(3'b101, 32'd50, 32'd7, 32'd7, "DIVU b2b", 0);

    chk("scoreboard empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
